fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//   Owns the program counter and instruction register of the multicycle CPU, directly upstream of the control FSM.
//   Issues instruction-memory requests and latches the fetched word into the IR that drives the FSM's instruction input.
//   Applies the FSM's PC_WE/PCSrc/IR_WE/Branch controls to update the PC.
//   Raises fetch_stall while instruction memory is not ready; the FSM holds its IF state while fetch_stall=1.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   TIMEOUT    8'd255         WAIT cycles before fetch_err is raised
// PORTS
//   clk          in   1   system clock, all state on posedge
//   rst_n        in   1   asynchronous active-low reset
//   pc_we        in   1   FSM PC_WE
//   pc_src       in   2   FSM PCSrc: 0=hold, 1=alu_result, 2=jump target, 3=hold
//   ir_we        in   1   FSM IR_WE (fetch cycle)
//   branch       in   4   FSM Branch: 1=BEQ, 2=BNE, other=no branch
//   alu_zero     in   1   datapath ALU zero flag
//   alu_result   in   32  datapath ALU result (JR target)
//   imem_rdata   in   32  instruction memory read data
//   imem_valid   in   1   imem_rdata valid for imem_addr this cycle
//   imem_addr    out  32  fetch address (= pc)
//   imem_req     out  1   fetch request
//   instruction  out  32  instruction register, to FSM and datapath
//   pc           out  32  current PC (PC+4 of current instr once fetched; JAL link value)
//   fetch_stall  out  1   fetch pending, FSM must hold
//   misalign     out  1   sticky: a PC write had nonzero bits [1:0]
//   fetch_err    out  1   sticky: WAIT exceeded TIMEOUT cycles
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, instruction=0, state=RUN, misalign=0, fetch_err=0, wait count=0.
//   Reset mid-WAIT aborts the fetch; no IR/PC update; fetch_stall drops immediately (combinational from state).
//   States: RUN, WAIT. imem_addr=pc always. imem_req = ir_we | (state==WAIT).
//   fetch_stall = imem_req & ~imem_valid (combinational).
//   Fetch (imem_req & imem_valid): instruction<=imem_rdata, pc<=pc+4 (own incrementer, pc_src ignored), state<=RUN, count<=0.
//     Zero-wait memory -> fetch completes in the IR_WE cycle, no stall.
//   RUN & ir_we & ~imem_valid -> WAIT; pc and instruction unchanged. WAIT & ~imem_valid -> stay, count++.
//   count reaching TIMEOUT -> fetch_err<=1 (sticky); fetch stays pending; count saturates.
//   Non-fetch PC update (no fetch completing and state==RUN), priority order:
//     1. pc_we & pc_src==1 -> pc<=alu_result
//     2. pc_we & pc_src==2 -> pc<={pc[31:28], instruction[25:0], 2'b00}
//     3. pc_we & pc_src in {0,3} -> pc held
//     4. branch==1 & alu_zero, or branch==2 & ~alu_zero -> pc<=pc + (sext(instruction[15:0])<<2)
//     5. otherwise hold. Branch codes other than 1/2 never redirect.
//   Wrap: pc arithmetic is modulo 2^32 (0xFFFF_FFFC+4 = 0).
//   Misalign: any PC write whose target bits[1:0]!=0 -> misalign<=1 (sticky); written pc forced to {target[31:2],2'b00}.
//   pc_we/branch during WAIT are ignored (FSM is held in IF).
//   ir_we & pc_we in the same cycle is the normal IF case: fetch path wins.
//   instruction changes only on a completed fetch.
// TESTING
//   Reset, RESET_PC=0x100, ir_we=1, imem_valid=1, rdata=0x8C01_0004 -> instruction=0x8C01_0004, pc=0x104, stall never high.
//   ir_we=1, imem_valid low 3 cycles -> fetch_stall=1 for 3 cycles, pc/IR held, capture on 4th cycle; fetch_err stays 0.
//   pc=0x104, IR imm=0xFFFF, branch=1, alu_zero=1 -> pc=0x100.
//     branch=2 with alu_zero=1 -> pc stays 0x104.
//   pc=0x1000_0004, IR=0x0800_0010, pc_we=1, pc_src=2 -> pc=0x1000_0040.
//     pc_src=1, alu_result=0x206 -> pc=0x204, misalign=1.
//   TIMEOUT=4, imem_valid held low -> fetch_err=1 after 4 WAIT cycles.
//     rst_n pulsed low mid-WAIT -> pc=RESET_PC, instruction=0, stall=0, flags cleared.
//   pc=0xFFFF_FFFC, fetch completes -> pc=0x0000_0000.

Source files
------------

// File: rtl/fetch_pc_if.sv
// Fetch/PC bus between the control FSM side (master) and the fetch_pc_unit (slave).
// The slave modport also carries the instruction-memory request/response signals.
interface fetch_pc_if;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic [3:0]  branch;
    logic        alu_zero;
    logic [31:0] alu_result;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_stall;
    logic        misalign;
    logic        fetch_err;

    modport master (
        output pc_we, pc_src, ir_we, branch, alu_zero, alu_result, imem_rdata, imem_valid,
        input  imem_addr, imem_req, instruction, pc, fetch_stall, misalign, fetch_err
    );

    modport slave (
        input  pc_we, pc_src, ir_we, branch, alu_zero, alu_result, imem_rdata, imem_valid,
        output imem_addr, imem_req, instruction, pc, fetch_stall, misalign, fetch_err
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction register of the multicycle CPU.
// Issues instruction fetches, stalls the FSM on slow memory and applies PC redirects.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_pc_if.slave      bus
);
    typedef enum logic {RUN, WAIT} state_t;

    state_t      state_reg;
    logic [7:0]  count_reg;
    logic [31:0] pc_reg;
    logic [31:0] instruction_reg;
    logic        misalign_reg;
    logic        fetch_err_reg;

    logic        fetch_done;
    logic        branch_taken;
    logic        pc_write;
    logic [31:0] pc_target;
    logic [31:0] branch_offset;

    assign bus.imem_addr   = pc_reg;
    assign bus.imem_req    = bus.ir_we | (state_reg == WAIT);
    assign bus.fetch_stall = bus.imem_req & ~bus.imem_valid;
    assign bus.instruction = instruction_reg;
    assign bus.pc          = pc_reg;
    assign bus.misalign    = misalign_reg;
    assign bus.fetch_err   = fetch_err_reg;

    assign fetch_done    = bus.imem_req & bus.imem_valid;
    assign branch_offset = {{14{instruction_reg[15]}}, instruction_reg[15:0], 2'b00};
    assign branch_taken  = ((bus.branch == 4'd1) &  bus.alu_zero) |
                           ((bus.branch == 4'd2) & ~bus.alu_zero);

    // A completing fetch always wins; redirects only apply while not waiting on memory.
    always_comb begin
        pc_write  = 1'b0;
        pc_target = pc_reg;
        if (fetch_done) begin
            pc_write  = 1'b1;
            pc_target = pc_reg + 32'd4;
        end else if (state_reg == RUN) begin
            if (bus.pc_we) begin
                if (bus.pc_src == 2'd1) begin
                    pc_write  = 1'b1;
                    pc_target = bus.alu_result;
                end else if (bus.pc_src == 2'd2) begin
                    pc_write  = 1'b1;
                    pc_target = {pc_reg[31:28], instruction_reg[25:0], 2'b00};
                end
            end else if (branch_taken) begin
                pc_write  = 1'b1;
                pc_target = pc_reg + branch_offset;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            count_reg       <= 8'd0;
            pc_reg          <= RESET_PC;
            instruction_reg <= 32'd0;
            misalign_reg    <= 1'b0;
            fetch_err_reg   <= 1'b0;
        end else begin
            if (pc_write) begin
                pc_reg <= {pc_target[31:2], 2'b00};
                if (pc_target[1:0] != 2'b00) begin
                    misalign_reg <= 1'b1;
                end
            end
            if (fetch_done) begin
                instruction_reg <= bus.imem_rdata;
                state_reg       <= RUN;
                count_reg       <= 8'd0;
            end else if (state_reg == RUN) begin
                if (bus.ir_we) begin
                    state_reg <= WAIT;
                end
            end else if (count_reg != TIMEOUT) begin
                // Count saturates at TIMEOUT; the fetch itself stays pending.
                count_reg <= count_reg + 8'd1;
                if (count_reg == TIMEOUT - 8'd1) begin
                    fetch_err_reg <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: expected post-edge state is queued at drive time
// and popped after the clock edge for comparison.
module tb_fetch_pc_unit;
    logic clk;
    logic rst_n;

    fetch_pc_if bus ();

    fetch_pc_unit #(
        .RESET_PC (32'h0000_0100),
        .TIMEOUT  (8'd4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] ir;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(
        input string       tag,
        input logic        ir_we,
        input logic        pc_we,
        input logic [1:0]  pc_src,
        input logic [3:0]  branch,
        input logic        zero,
        input logic [31:0] alu,
        input logic        valid,
        input logic [31:0] rdata,
        input logic        exp_stall,
        input logic [31:0] exp_pc,
        input logic [31:0] exp_ir,
        input logic        exp_mis,
        input logic        exp_err
    );
        exp_t e;
        bus.ir_we      = ir_we;
        bus.pc_we      = pc_we;
        bus.pc_src     = pc_src;
        bus.branch     = branch;
        bus.alu_zero   = zero;
        bus.alu_result = alu;
        bus.imem_valid = valid;
        bus.imem_rdata = rdata;
        e.tag = tag; e.pc = exp_pc; e.ir = exp_ir; e.mis = exp_mis; e.err = exp_err;
        exp_q.push_back(e);
        #1;
        check_val({tag, ".stall"}, {31'd0, bus.fetch_stall}, {31'd0, exp_stall});
        check_val({tag, ".addr"}, bus.imem_addr, bus.pc);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({e.tag, ".pc"}, bus.pc, e.pc);
        check_val({e.tag, ".ir"}, bus.instruction, e.ir);
        check_val({e.tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, e.mis});
        check_val({e.tag, ".fetch_err"}, {31'd0, bus.fetch_err}, {31'd0, e.err});
        $display("txn %-10s pc=0x%08h ir=0x%08h mis=%0b err=%0b", e.tag, bus.pc, bus.instruction,
                 bus.misalign, bus.fetch_err);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, ".pc"}, bus.pc, 32'h0000_0100);
        check_val({tag, ".ir"}, bus.instruction, 32'd0);
        check_val({tag, ".stall"}, {31'd0, bus.fetch_stall}, 32'd0);
        check_val({tag, ".misalign"}, {31'd0, bus.misalign}, 32'd0);
        check_val({tag, ".fetch_err"}, {31'd0, bus.fetch_err}, 32'd0);
        $display("txn %-10s pc=0x%08h ir=0x%08h stall=%0b", tag, bus.pc, bus.instruction, bus.fetch_stall);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.ir_we = 1'b0; bus.pc_we = 1'b0; bus.pc_src = 2'd0; bus.branch = 4'd0;
        bus.alu_zero = 1'b0; bus.alu_result = 32'd0; bus.imem_valid = 1'b0; bus.imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        //   tag          irwe pcwe src br  z  alu            v  rdata          stall pc             ir             mis err
        cyc("fetch0",     1, 0, 2'd0, 4'd0, 0, 32'd0,         1, 32'h8C01_0004, 0, 32'h0000_0104, 32'h8C01_0004, 0, 0);
        cyc("stall1",     1, 0, 2'd0, 4'd0, 0, 32'd0,         0, 32'hDEAD_BEEF, 1, 32'h0000_0104, 32'h8C01_0004, 0, 0);
        cyc("stall2",     1, 0, 2'd0, 4'd0, 0, 32'd0,         0, 32'hDEAD_BEEF, 1, 32'h0000_0104, 32'h8C01_0004, 0, 0);
        cyc("stall3",     1, 0, 2'd0, 4'd0, 0, 32'd0,         0, 32'hDEAD_BEEF, 1, 32'h0000_0104, 32'h8C01_0004, 0, 0);
        cyc("capture",    1, 0, 2'd0, 4'd0, 0, 32'd0,         1, 32'h1000_FFFF, 0, 32'h0000_0108, 32'h1000_FFFF, 0, 0);
        cyc("beq_take",   0, 0, 2'd0, 4'd1, 1, 32'd0,         0, 32'd0,         0, 32'h0000_0104, 32'h1000_FFFF, 0, 0);
        cyc("bne_hold",   0, 0, 2'd0, 4'd2, 1, 32'd0,         0, 32'd0,         0, 32'h0000_0104, 32'h1000_FFFF, 0, 0);
        cyc("bne_take",   0, 0, 2'd0, 4'd2, 0, 32'd0,         0, 32'd0,         0, 32'h0000_0100, 32'h1000_FFFF, 0, 0);
        cyc("br3_hold",   0, 0, 2'd0, 4'd3, 0, 32'd0,         0, 32'd0,         0, 32'h0000_0100, 32'h1000_FFFF, 0, 0);
        cyc("beq_hold",   0, 0, 2'd0, 4'd1, 0, 32'd0,         0, 32'd0,         0, 32'h0000_0100, 32'h1000_FFFF, 0, 0);
        cyc("jr_set",     0, 1, 2'd1, 4'd0, 0, 32'h1000_0000, 0, 32'd0,         0, 32'h1000_0000, 32'h1000_FFFF, 0, 0);
        cyc("fetch_j",    1, 0, 2'd0, 4'd0, 0, 32'd0,         1, 32'h0800_0010, 0, 32'h1000_0004, 32'h0800_0010, 0, 0);
        cyc("jump",       0, 1, 2'd2, 4'd0, 0, 32'd0,         0, 32'd0,         0, 32'h1000_0040, 32'h0800_0010, 0, 0);
        cyc("jr_vs_br",   0, 1, 2'd1, 4'd1, 1, 32'h1234_5678, 0, 32'd0,         0, 32'h1234_5678, 32'h0800_0010, 0, 0);
        cyc("src0_hold",  0, 1, 2'd0, 4'd1, 1, 32'd0,         0, 32'd0,         0, 32'h1234_5678, 32'h0800_0010, 0, 0);
        cyc("src3_hold",  0, 1, 2'd3, 4'd1, 1, 32'd0,         0, 32'd0,         0, 32'h1234_5678, 32'h0800_0010, 0, 0);
        cyc("beq_fwd",    0, 0, 2'd0, 4'd1, 1, 32'd0,         0, 32'd0,         0, 32'h1234_56B8, 32'h0800_0010, 0, 0);
        cyc("misalign",   0, 1, 2'd1, 4'd0, 0, 32'h0000_0206, 0, 32'd0,         0, 32'h0000_0204, 32'h0800_0010, 1, 0);
        cyc("mis_stick",  1, 0, 2'd0, 4'd0, 0, 32'd0,         1, 32'h0000_0000, 0, 32'h0000_0208, 32'h0000_0000, 1, 0);
        cyc("to_top",     0, 1, 2'd1, 4'd0, 0, 32'hFFFF_FFFC, 0, 32'd0,         0, 32'hFFFF_FFFC, 32'h0000_0000, 1, 0);
        cyc("wrap",       1, 0, 2'd0, 4'd0, 0, 32'd0,         1, 32'hAABB_CCDD, 0, 32'h0000_0000, 32'hAABB_CCDD, 1, 0);
        cyc("if_wins",    1, 1, 2'd1, 4'd0, 0, 32'h0000_0500, 1, 32'h1122_3344, 0, 32'h0000_0004, 32'h1122_3344, 1, 0);
        cyc("wait_in",    1, 0, 2'd0, 4'd0, 0, 32'd0,         0, 32'd0,         1, 32'h0000_0004, 32'h1122_3344, 1, 0);
        cyc("wait_pcwe",  0, 1, 2'd1, 4'd0, 0, 32'h0000_0800, 0, 32'd0,         1, 32'h0000_0004, 32'h1122_3344, 1, 0);
        cyc("wait_br",    0, 0, 2'd0, 4'd1, 1, 32'd0,         0, 32'd0,         1, 32'h0000_0004, 32'h1122_3344, 1, 0);
        cyc("wait_3",     0, 0, 2'd0, 4'd0, 0, 32'd0,         0, 32'd0,         1, 32'h0000_0004, 32'h1122_3344, 1, 0);
        cyc("wait_4",     0, 0, 2'd0, 4'd0, 0, 32'd0,         0, 32'd0,         1, 32'h0000_0004, 32'h1122_3344, 1, 1);
        cyc("wait_sat",   0, 0, 2'd0, 4'd0, 0, 32'd0,         0, 32'd0,         1, 32'h0000_0004, 32'h1122_3344, 1, 1);

        // Asynchronous reset pulse while the fetch is still pending.
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_wait");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("rst_held");

        cyc("refetch",    1, 0, 2'd0, 4'd0, 0, 32'd0,         1, 32'h8C01_0004, 0, 32'h0000_0104, 32'h8C01_0004, 0, 0);

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
